// File: rtl/sram_ctrl.sv
// rtl/sram_ctrl.sv - single-byte async 128Kx8 SRAM access controller fed by 28-bit command words
// Optional feature macro: SRAM_CLEAR_EN (opcode 101 fills the whole array with cmd_word[7:0]).
module sram_ctrl #(
    parameter int WAIT_CYCLES = 2,
    parameter int ADDR_W      = 17
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [27:0]       cmd_word,
    output logic [7:0]        rdata,
    output logic              rdata_valid,
    output logic              cmd_err,
    output logic              cen,
    output logic              oen,
    output logic              wen,
    output logic [ADDR_W-1:0] addr,
    inout  wire  [7:0]        data
);
    localparam logic [2:0] OP_NOP        = 3'b000;
    localparam logic [2:0] OP_WRITE      = 3'b001;
    localparam logic [2:0] OP_READ       = 3'b010;
    localparam logic [2:0] OP_READ_NEXT  = 3'b011;
    localparam logic [2:0] OP_WRITE_NEXT = 3'b100;
`ifdef SRAM_CLEAR_EN
    localparam logic [2:0] OP_CLEAR      = 3'b101;
`endif
    localparam logic [3:0] ACCESS_LAST   = 4'(WAIT_CYCLES - 1);

    typedef enum logic [1:0] {IDLE, SETUP, ACCESS, HOLD} state_t;

    state_t              state_q;
    logic [3:0]          cnt_q;
    logic                is_read_q;
    logic                clear_q;
    logic                data_oe_q;
    logic [7:0]          wdata_q;
    logic [ADDR_W-1:0]   ptr_q;
    logic [ADDR_W-1:0]   addr_q;
    logic [7:0]          rdata_q;
    logic                rdata_valid_q;
    logic                cmd_err_q;
    logic                cmd_ready_q;
    logic                cen_q;
    logic                oen_q;
    logic                wen_q;

    logic [2:0]          cmd_op;
    logic [ADDR_W-1:0]   cmd_addr;
    logic [ADDR_W-1:0]   ptr_next;
    logic [ADDR_W-1:0]   eff_addr;

    assign cmd_op   = cmd_word[27:25];
    assign cmd_addr = cmd_word[8 +: ADDR_W];
    assign ptr_next = ptr_q + ADDR_W'(1);
    assign eff_addr = (cmd_op == OP_READ_NEXT || cmd_op == OP_WRITE_NEXT) ? ptr_next : cmd_addr;

    assign data        = data_oe_q ? wdata_q : 8'bz;
    assign cmd_ready   = cmd_ready_q;
    assign rdata       = rdata_q;
    assign rdata_valid = rdata_valid_q;
    assign cmd_err     = cmd_err_q;
    assign cen         = cen_q;
    assign oen         = oen_q;
    assign wen         = wen_q;
    assign addr        = addr_q;

    // Every output is set on the edge entering the phase it belongs to, so strobes never glitch.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= IDLE;
            cnt_q         <= '0;
            is_read_q     <= 1'b0;
            clear_q       <= 1'b0;
            data_oe_q     <= 1'b0;
            wdata_q       <= '0;
            ptr_q         <= '0;
            addr_q        <= '0;
            rdata_q       <= '0;
            rdata_valid_q <= 1'b0;
            cmd_err_q     <= 1'b0;
            cmd_ready_q   <= 1'b1;
            cen_q         <= 1'b1;
            oen_q         <= 1'b1;
            wen_q         <= 1'b1;
        end else begin
            rdata_valid_q <= 1'b0;
            cmd_err_q     <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (cmd_valid && cmd_ready_q) begin
                        case (cmd_op)
                            OP_NOP: begin
                            end
                            OP_WRITE, OP_WRITE_NEXT: begin
                                addr_q      <= eff_addr;
                                ptr_q       <= eff_addr;
                                wdata_q     <= cmd_word[7:0];
                                data_oe_q   <= 1'b1;
                                is_read_q   <= 1'b0;
                                cen_q       <= 1'b0;
                                cmd_ready_q <= 1'b0;
                                state_q     <= SETUP;
                            end
                            OP_READ, OP_READ_NEXT: begin
                                addr_q      <= eff_addr;
                                ptr_q       <= eff_addr;
                                is_read_q   <= 1'b1;
                                cen_q       <= 1'b0;
                                oen_q       <= 1'b0;
                                cmd_ready_q <= 1'b0;
                                state_q     <= SETUP;
                            end
`ifdef SRAM_CLEAR_EN
                            OP_CLEAR: begin
                                addr_q      <= '0;
                                ptr_q       <= '1;
                                wdata_q     <= cmd_word[7:0];
                                data_oe_q   <= 1'b1;
                                is_read_q   <= 1'b0;
                                clear_q     <= 1'b1;
                                cen_q       <= 1'b0;
                                cmd_ready_q <= 1'b0;
                                state_q     <= SETUP;
                            end
`endif
                            default: cmd_err_q <= 1'b1;
                        endcase
                    end
                end
                SETUP: begin
                    if (!is_read_q) begin
                        wen_q <= 1'b0;
                    end
                    cnt_q   <= ACCESS_LAST;
                    state_q <= ACCESS;
                end
                ACCESS: begin
                    if (cnt_q == 4'd0) begin
                        wen_q   <= 1'b1;
                        oen_q   <= 1'b1;
                        state_q <= HOLD;
                        if (is_read_q) begin
                            rdata_q       <= data;
                            rdata_valid_q <= 1'b1;
                        end
                    end else begin
                        cnt_q <= cnt_q - 4'd1;
                    end
                end
                HOLD: begin
                    // A fill chains straight into the next address with cen still low.
                    if (clear_q && addr_q != '1) begin
                        addr_q  <= addr_q + ADDR_W'(1);
                        state_q <= SETUP;
                    end else begin
                        clear_q     <= 1'b0;
                        cen_q       <= 1'b1;
                        data_oe_q   <= 1'b0;
                        cmd_ready_q <= 1'b1;
                        state_q     <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end
endmodule
